// File: rtl/preset_writer.sv
// Flash write-back engine for the button preset table: snapshot, sector erase,
// then one word program per slot over the stb/ack/rty flash request bus.
//
// state     | meaning
// S_IDLE    | waiting for save_req
// S_ERASE   | issue sector erase
// S_WRITE   | issue word program for current slot
// S_WAIT    | request outstanding, waiting for ack_i/rty_i
// S_RELEASE | waiting for ack_i and rty_i to drop
// S_DONE    | pulse done, return to idle
// S_FAIL    | retries exhausted, set fail, return to idle
module preset_writer #(
   parameter int          BUTTONS_CNT = 4,
   parameter logic [23:0] MEMADDR     = 24'h1ffd80,
   parameter int          RETRY_MAX   = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       save_req,
   input  logic [32*BUTTONS_CNT-1:0]  table_i,
   output logic [23:0]                adr_o,
   output logic [31:0]                dat_o,
   output logic                       we_o,
   output logic                       stb_o,
   output logic                       tga_o,
   input  logic                       ack_i,
   input  logic                       rty_i,
   output logic                       busy,
   output logic                       done,
   output logic                       fail
);

   localparam int SW = (BUTTONS_CNT > 1) ? $clog2(BUTTONS_CNT) : 1;
   localparam int RW = $clog2(RETRY_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ERASE, S_WRITE, S_WAIT, S_RELEASE, S_DONE, S_FAIL
   } state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] slot_q, slot_d;
   logic [RW-1:0] retry_q, retry_d;
   logic          erase_q, erase_d;
   logic          last_q, last_d;
   logic [31:0]   snap_q [BUTTONS_CNT];
   logic [31:0]   snap_d [BUTTONS_CNT];
   logic [23:0]   adr_q, adr_d;
   logic [31:0]   dat_q, dat_d;
   logic          we_q, we_d;
   logic          stb_q, stb_d;
   logic          tga_q, tga_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          fail_q, fail_d;

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      retry_d = retry_q;
      erase_d = erase_q;
      last_d  = last_q;
      snap_d  = snap_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      we_d    = we_q;
      stb_d   = stb_q;
      tga_d   = tga_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      fail_d  = fail_q;
      case (state_q)
         S_IDLE: begin
            if (save_req) begin
               for (int i = 0; i < BUTTONS_CNT; i++) begin
                  snap_d[i] = table_i[32*i +: 32];
               end
               fail_d  = 1'b0;
               busy_d  = 1'b1;
               slot_d  = '0;
               retry_d = '0;
               erase_d = 1'b1;
               last_d  = 1'b0;
               state_d = S_ERASE;
            end
         end
         S_ERASE: begin
            stb_d   = 1'b1;
            we_d    = 1'b1;
            tga_d   = 1'b1;
            adr_d   = MEMADDR;
            state_d = S_WAIT;
         end
         S_WRITE: begin
            stb_d   = 1'b1;
            we_d    = 1'b1;
            tga_d   = 1'b0;
            adr_d   = MEMADDR + {{(22-SW){1'b0}}, slot_q, 2'b00};
            dat_d   = snap_q[slot_q];
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // ack_i has priority over a simultaneous rty_i
            if (ack_i) begin
               stb_d   = 1'b0;
               we_d    = 1'b0;
               retry_d = '0;
               if (erase_q) begin
                  erase_d = 1'b0;
                  slot_d  = '0;
               end else if (slot_q == SW'(BUTTONS_CNT - 1)) begin
                  last_d = 1'b1;
               end else begin
                  slot_d = slot_q + 1'b1;
               end
               state_d = S_RELEASE;
            end else if (rty_i) begin
               stb_d   = 1'b0;
               we_d    = 1'b0;
               retry_d = retry_q + 1'b1;
               state_d = (retry_q == RW'(RETRY_MAX - 1)) ? S_FAIL : S_RELEASE;
            end
         end
         S_RELEASE: begin
            if (!ack_i && !rty_i) begin
               if (last_q)       state_d = S_DONE;
               else if (erase_q) state_d = S_ERASE;
               else              state_d = S_WRITE;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         S_FAIL: begin
            fail_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         slot_q  <= '0;
         retry_q <= '0;
         erase_q <= 1'b0;
         last_q  <= 1'b0;
         for (int i = 0; i < BUTTONS_CNT; i++) begin
            snap_q[i] <= '0;
         end
         adr_q   <= '0;
         dat_q   <= '0;
         we_q    <= 1'b0;
         stb_q   <= 1'b0;
         tga_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         retry_q <= retry_d;
         erase_q <= erase_d;
         last_q  <= last_d;
         snap_q  <= snap_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         we_q    <= we_d;
         stb_q   <= stb_d;
         tga_q   <= tga_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         fail_q  <= fail_d;
      end
   end

   assign adr_o = adr_q;
   assign dat_o = dat_q;
   assign we_o  = we_q;
   assign stb_o = stb_q;
   assign tga_o = tga_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign fail  = fail_q;

endmodule

// File: doc/preset_writer.md
# preset_writer

Flash write-back engine for the button preset table. On a save request it snapshots the 16-byte preset table (4 buttons × status, data1, data2, bit count), erases the preset sector, then writes the table back as four 32-bit words through the same stb/ack/rty request bus that `spi_flash` exposes. It is the writer counterpart to the boot-time preset reader in the controller, and sits between the controller's save logic and the flash master port (muxed externally).

## Interface
- `BUTTONS_CNT`, 4, number of preset slots; one 32-bit word each.
- `MEMADDR`, 24'h1ffd80, flash byte address of slot 1; slot n is at MEMADDR + (n-1)*4.
- `RETRY_MAX`, 3, rty_i responses tolerated per operation before giving up.

- `clk`  in  1  system clock. Single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `save_req`  in  1  one-cycle request to save; sampled only in IDLE.
- `table_i`  in  32*BUTTONS_CNT  preset table; slot n word is bits [32n-1:32(n-1)], byte order status[31:24], data1[23:16], data2[15:8], bits_cnt[7:0].
- `adr_o`  out  24  flash byte address.
- `dat_o`  out  32  write data.
- `we_o`  out  1  1 = write/erase (always 1 when stb_o is high).
- `stb_o`  out  1  request strobe.
- `tga_o`  out  1  1 = sector erase, 0 = word program.
- `ack_i`  in  1  operation complete.
- `rty_i`  in  1  operation rejected; retry.
- `busy`  out  1  high from accept until DONE/FAIL exit.
- `done`  out  1  one-cycle pulse on successful completion.
- `fail`  out  1  level; set on retry exhaustion, cleared on next accepted save_req or rst.

## Operation
- Reset values: stb_o, we_o, tga_o, busy, done, fail = 0; adr_o, dat_o = 0; state IDLE; slot counter and retry counter = 0.
- IDLE: on save_req, latch table_i into an internal snapshot. Changes to table_i after that cycle are ignored. Clear fail, set busy, go ERASE.
- ERASE: drive stb_o=1, we_o=1, tga_o=1, adr_o=MEMADDR. Go WAIT.
- WRITE: drive stb_o=1, we_o=1, tga_o=0, adr_o=MEMADDR+slot*4, dat_o=snapshot word[slot]. Go WAIT.
- WAIT: hold stb_o and all request fields stable until ack_i or rty_i. If both are high, ack_i wins.
  - On ack_i: drop stb_o and go RELEASE. Next op: after ERASE, WRITE with slot 0; after WRITE, slot+1, or DONE if slot = BUTTONS_CNT-1. Reset the retry counter.
  - On rty_i: drop stb_o and increment the retry counter. If the counter reaches RETRY_MAX, go FAIL. Otherwise go RELEASE and reissue the same op.
- RELEASE: wait until ack_i=0 and rty_i=0 before issuing the next op. A held ack is never counted twice.
- DONE: pulse done for one cycle, clear busy, go IDLE.
- FAIL: set fail, clear busy, go IDLE. The flash contents are undefined; no rollback is attempted.
- save_req while busy: ignored, with no queueing.
- rst at any point: takes effect on the next clk edge. Outputs return to reset values, the in-flight operation is abandoned, and no done pulse is produced.

## Timing
- save_req high at edge N: busy=1 and stb_o=1 (erase) after edge N+1.
- ack_i high at edge M: stb_o=0 after edge M+1. The next stb_o rises one cycle after the first edge that samples ack_i=0 and rty_i=0.
- With a zero-wait responder (ack for exactly 1 cycle, 1 cycle after stb) the whole sequence is 5 ops. Each op costs 1 cycle in the issue state, 1 in WAIT and 1 in RELEASE, so done pulses 3*5+1 cycles after accept.
- done and the busy fall occur in the same cycle.
- Address arithmetic is 24-bit; the slot index is 2 bits (log2 BUTTONS_CNT). MEMADDR+12 must not cross a sector; this is a configuration rule and is not checked.

## Test plan
- **Normal save:** table_i slot words 0xB02E7F1E, 0xC0420014, 0xC0430014, 0xB02F7F1E; responder acks after 3 cycles. Required bus order:
  - erase at 1ffd80 (tga_o=1);
  - writes of 1ffd80=B02E7F1E, 1ffd84=C0420014, 1ffd88=C0430014, 1ffd8c=B02F7F1E;
  - one done pulse; fail=0.
- **Snapshot:** change table_i the cycle after save_req. The written data must equal the pre-change values.
- **Single retry:** the first write to 1ffd84 returns rty_i. Required: the same address and data are reissued, the sequence completes, done pulses, fail=0.
- **Retry exhaustion:** erase returns rty_i 3 times. Required: no writes issued, fail=1, done never high, busy=0.
- **Long ack:** ack_i held for 10 cycles. Required: exactly one slot advance; stb_o stays low until ack_i falls.
- **Abort and busy request:**
  - save_req pulsed while busy: no second sequence starts.
  - rst during the write to 1ffd88: stb_o=0 and busy=0 on the next edge; a new save_req then restarts from the erase.
